// File: rtl/audio_gain_pkg.sv
// audio_gain_pkg
// Shared constants for the audio gain ramp block: CSR offsets, CTRL bit
// positions, reset value of CTRL and the signed saturation helper used by
// the output stage.
package audio_gain_pkg;

  // CSR word addresses
  localparam logic [5:0] CSR_CTRL_ADDR = 6'd0;
  localparam int         DEF_GAIN_BASE = 16;
  localparam int         DEF_CUR_BASE  = 32;

  // CTRL register layout and reset value (ramp enabled, unmuted)
  localparam int         CTRL_MUTE_BIT = 0;
  localparam int         CTRL_RAMP_BIT = 1;
  localparam logic [1:0] CTRL_RESET    = 2'b10;

  // Working width of the saturation helper
  localparam int SAT_W = 64;

  // Clamp a signed value to the range of a signed 'width'-bit number.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int                      width
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    logic signed [SAT_W-1:0] res;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) begin
      res = max_v;
    end else if (value < min_v) begin
      res = min_v;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_gain_ramp_if.sv
// audio_gain_ramp_if
// Bundles the CSR slave port (avs_*), the Avalon-ST sink (snk_*) and the
// Avalon-ST source (src_*) of audio_gain_ramp.
//   master : drives CSR strobes, sink samples and src_ready (system side)
//   slave  : the gain block itself
interface audio_gain_ramp_if #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 24
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [5:0]               avs_address;
  logic                     avs_write;
  logic                     avs_read;
  logic [31:0]              avs_writedata;
  logic [31:0]              avs_readdata;

  logic                     snk_valid;
  logic                     snk_ready;
  logic signed [DATA_W-1:0] snk_data;
  logic [CH_W-1:0]          snk_channel;

  logic                     src_valid;
  logic                     src_ready;
  logic signed [DATA_W-1:0] src_data;
  logic [CH_W-1:0]          src_channel;

  modport master (
    output avs_address, avs_write, avs_read, avs_writedata,
    input  avs_readdata,
    output snk_valid, snk_data, snk_channel,
    input  snk_ready,
    input  src_valid, src_data, src_channel,
    output src_ready
  );

  modport slave (
    input  avs_address, avs_write, avs_read, avs_writedata,
    output avs_readdata,
    input  snk_valid, snk_data, snk_channel,
    output snk_ready,
    output src_valid, src_data, src_channel,
    input  src_ready
  );
endinterface

// File: rtl/gain_ramp_channel.sv
// gain_ramp_channel
// Per-channel target and current gain registers plus the step logic.
// Ports:
//   clk, reset_n : clock, async active-low reset (both gains -> unity)
//   i_wr_en      : CSR write to this channel's target
//   i_wr_data    : new target value
//   i_mute       : force the effective target to zero
//   i_ramp_en    : 1 = step one LSB per transfer, 0 = track target directly
//   i_step       : a sample of this channel is being transferred
//   o_target     : programmed target gain
//   o_cur        : current gain applied to samples
module gain_ramp_channel #(
  parameter int GAIN_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr_en,
  input  logic [GAIN_W-1:0] i_wr_data,
  input  logic              i_mute,
  input  logic              i_ramp_en,
  input  logic              i_step,
  output logic [GAIN_W-1:0] o_target,
  output logic [GAIN_W-1:0] o_cur
);
  localparam int                FRAC  = GAIN_W - 2;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << FRAC;

  logic [GAIN_W-1:0] r_target;
  logic [GAIN_W-1:0] r_cur;
  logic [GAIN_W-1:0] w_eff;
  logic [GAIN_W-1:0] w_cur_nxt;

  // Effective target: muting overrides the programmed target
  always_comb begin
    w_eff = r_target;
    if (i_mute) begin
      w_eff = {GAIN_W{1'b0}};
    end else begin
      w_eff = r_target;
    end
  end

  // Next current gain. The step uses the registered target, so a write
  // landing in the same cycle as a transfer only affects later transfers.
  always_comb begin
    w_cur_nxt = r_cur;
    if (!i_ramp_en) begin
      w_cur_nxt = w_eff;
    end else if (i_step) begin
      if (r_cur < w_eff) begin
        w_cur_nxt = r_cur + GAIN_W'(1);
      end else if (r_cur > w_eff) begin
        w_cur_nxt = r_cur - GAIN_W'(1);
      end else begin
        w_cur_nxt = r_cur;
      end
    end else begin
      w_cur_nxt = r_cur;
    end
  end

  // Target register, loaded by CSR writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_target <= UNITY;
    end else if (i_wr_en) begin
      r_target <= i_wr_data;
    end
  end

  // Current gain register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur <= UNITY;
    end else begin
      r_cur <= w_cur_nxt;
    end
  end

  assign o_target = r_target;
  assign o_cur    = r_cur;
endmodule

// File: rtl/audio_gain_ramp.sv
// audio_gain_ramp
// Multi-channel audio gain stage with per-channel gain ramping and mute.
// Samples are multiplied by the channel's current gain (fixed point with
// GAIN_W-2 fraction bits), shifted back, and saturated to DATA_W bits in a
// two-stage elastic pipeline.
// Ports:
//   clk     : single clock
//   reset_n : async active-low reset
//   bus     : audio_gain_ramp_if.slave -- CSR (avs_*), sink (snk_*),
//             source (src_*)
module audio_gain_ramp
  import audio_gain_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DATA_W    = 24,
  parameter int GAIN_W    = 8,
  parameter int GAIN_BASE = DEF_GAIN_BASE,
  parameter int CUR_BASE  = DEF_CUR_BASE
) (
  input  logic                clk,
  input  logic                reset_n,
  audio_gain_ramp_if.slave    bus
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FRAC   = GAIN_W - 2;
  localparam int PROD_W = DATA_W + GAIN_W + 1;

  logic [1:0]               r_ctrl;
  logic [31:0]              r_readdata;
  logic                     r_s1_valid;
  logic signed [PROD_W-1:0] r_s1_prod;
  logic [CH_W-1:0]          r_s1_ch;
  logic                     r_s2_valid;
  logic signed [DATA_W-1:0] r_s2_data;
  logic [CH_W-1:0]          r_s2_ch;

  logic                     w_mute;
  logic                     w_ramp_en;
  logic                     w_ctrl_wr;
  logic                     w_s2_ready;
  logic                     w_s1_adv;
  logic                     w_snk_ready;
  logic                     w_xfer;
  logic                     w_ch_ok;
  logic [GAIN_W-1:0]        w_gain;
  logic signed [PROD_W-1:0] w_data_ext;
  logic signed [PROD_W-1:0] w_gain_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_shift;
  logic signed [DATA_W-1:0] w_s2_data;
  logic [31:0]              w_rd_data;
  logic [GAIN_W-1:0]        w_tgt    [CHANNELS];
  logic [GAIN_W-1:0]        w_cur    [CHANNELS];
  logic [31:0]              w_rd_gain[CHANNELS];
  logic [31:0]              w_rd_cur [CHANNELS];
  logic [31-GAIN_W:0]       w_unused_wdata;

  assign w_mute         = r_ctrl[CTRL_MUTE_BIT];
  assign w_ramp_en      = r_ctrl[CTRL_RAMP_BIT];
  assign w_ctrl_wr      = bus.avs_write & (bus.avs_address == CSR_CTRL_ADDR);
  assign w_unused_wdata = bus.avs_writedata[31:GAIN_W];

  // Pipeline flow control: a stage accepts when empty or when it empties
  assign w_s2_ready  = ~r_s2_valid | bus.src_ready;
  assign w_s1_adv    = r_s1_valid & w_s2_ready;
  assign w_snk_ready = ~r_s1_valid | w_s1_adv;
  assign w_xfer      = bus.snk_valid & w_snk_ready;
  assign w_ch_ok     = int'(bus.snk_channel) < CHANNELS;

  // Per-channel gain state and CSR readback terms
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [5:0]      GADDR = 6'(GAIN_BASE + c);
    localparam logic [5:0]      CADDR = 6'(CUR_BASE + c);
    localparam logic [CH_W-1:0] CH_ID = CH_W'(c);
    logic w_wr_en;
    logic w_step;

    assign w_wr_en = bus.avs_write & (bus.avs_address == GADDR);
    assign w_step  = w_xfer & w_ch_ok & (bus.snk_channel == CH_ID);

    gain_ramp_channel #(
      .GAIN_W (GAIN_W)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_en   (w_wr_en),
      .i_wr_data (bus.avs_writedata[GAIN_W-1:0]),
      .i_mute    (w_mute),
      .i_ramp_en (w_ramp_en),
      .i_step    (w_step),
      .o_target  (w_tgt[c]),
      .o_cur     (w_cur[c])
    );

    assign w_rd_gain[c] = (bus.avs_address == GADDR) ? 32'(w_tgt[c]) : 32'd0;
    assign w_rd_cur[c]  = (bus.avs_address == CADDR) ? 32'(w_cur[c]) : 32'd0;
  end

  // CSR read mux; unmapped addresses fall through as zero
  always_comb begin
    w_rd_data = (bus.avs_address == CSR_CTRL_ADDR) ? {30'd0, r_ctrl} : 32'd0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_rd_data = w_rd_data | w_rd_gain[c] | w_rd_cur[c];
    end
  end

  // Gain select: out-of-range channels pass with zero gain
  always_comb begin
    w_gain = {GAIN_W{1'b0}};
    if (w_ch_ok) begin
      w_gain = w_cur[bus.snk_channel];
    end else begin
      w_gain = {GAIN_W{1'b0}};
    end
  end

  // Gain is zero-extended by one bit so the signed multiply treats it as
  // non-negative
  assign w_data_ext = PROD_W'(bus.snk_data);
  assign w_gain_ext = $signed(PROD_W'({1'b0, w_gain}));
  assign w_prod     = w_data_ext * w_gain_ext;

  assign w_shift   = r_s1_prod >>> FRAC;
  assign w_s2_data = DATA_W'(sat_signed(SAT_W'(w_shift), DATA_W));

  // CTRL register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl <= CTRL_RESET;
    end else if (w_ctrl_wr) begin
      r_ctrl <= bus.avs_writedata[1:0];
    end
  end

  // Registered CSR read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else if (bus.avs_read) begin
      r_readdata <= w_rd_data;
    end
  end

  // Stage 1: multiply
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= {PROD_W{1'b0}};
      r_s1_ch    <= {CH_W{1'b0}};
    end else if (w_snk_ready) begin
      r_s1_valid <= bus.snk_valid;
      r_s1_prod  <= w_prod;
      r_s1_ch    <= bus.snk_channel;
    end
  end

  // Stage 2: shift and saturate; holds while the sink stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= {DATA_W{1'b0}};
      r_s2_ch    <= {CH_W{1'b0}};
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= w_s2_data;
      r_s2_ch    <= r_s1_ch;
    end
  end

  assign bus.snk_ready    = w_snk_ready;
  assign bus.src_valid    = r_s2_valid;
  assign bus.src_data     = r_s2_data;
  assign bus.src_channel  = r_s2_ch;
  assign bus.avs_readdata = r_readdata;
endmodule
